// File: rtl/fifo.sv
// fifo: first-word fall-through queue with NUM_SLOTS words of DATA_WIDTH bits.
// Pointers wrap modulo NUM_SLOTS; a separate occupancy count drives the flags,
// so full and empty are unambiguous even when the pointers coincide.
module fifo #(
  parameter int NUM_SLOTS     = 4,
  parameter int LOG_NUM_SLOTS = 2,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic                  write,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] data_read,
  input  logic                  next_read,
  output logic                  empty
);

  localparam logic [LOG_NUM_SLOTS:0]   FULL_COUNT   = (LOG_NUM_SLOTS+1)'(NUM_SLOTS);
  localparam logic [LOG_NUM_SLOTS:0]   ALMOST_COUNT = (LOG_NUM_SLOTS+1)'(NUM_SLOTS - 1);
  localparam logic [LOG_NUM_SLOTS:0]   ZERO_COUNT   = '0;
  localparam logic [LOG_NUM_SLOTS:0]   ONE_COUNT    = (LOG_NUM_SLOTS+1)'(1);
  localparam logic [LOG_NUM_SLOTS-1:0] ONE_PTR      = LOG_NUM_SLOTS'(1);

  logic [DATA_WIDTH-1:0]    mem_q [NUM_SLOTS];
  logic [LOG_NUM_SLOTS-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_NUM_SLOTS-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_NUM_SLOTS:0]   count_q, count_d;
  logic                     do_write_s;
  logic                     do_pop_s;

  // Flags come straight from the registered count; the head word falls through.
  always_comb begin
    empty       = (count_q == ZERO_COUNT);
    full        = (count_q == FULL_COUNT);
    almost_full = (count_q == ALMOST_COUNT);
    data_read   = mem_q[rd_ptr_q];
  end

  // Next-state for pointers and count; reset wins over any request.
  always_comb begin
    do_write_s = write && !full;
    do_pop_s   = next_read && !empty;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (!rst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = ZERO_COUNT;
    end else begin
      if (do_write_s) begin
        wr_ptr_d = wr_ptr_q + ONE_PTR;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + ONE_PTR;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_write_s, do_pop_s})
        2'b10:   count_d = count_q + ONE_COUNT;
        2'b01:   count_d = count_q - ONE_COUNT;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  // Storage array; contents need no reset since empty qualifies data_read.
  always_ff @(posedge clk) begin
    if (rst && do_write_s) begin
      mem_q[wr_ptr_q] <= data_write;
    end
  end

endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed scenarios plus randomized traffic, checked against a
// queue-based reference model of the FIFO.
module tb_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_write = 8'h00;
  logic       write = 1'b0;
  logic       next_read = 1'b0;
  logic       full, almost_full, empty;
  logic [7:0] data_read;

  int checks   = 0;
  int failures = 0;
  logic [7:0] mq[$];

  fifo #(.NUM_SLOTS(4), .LOG_NUM_SLOTS(2), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .data_write(data_write), .write(write),
    .full(full), .almost_full(almost_full), .data_read(data_read),
    .next_read(next_read), .empty(empty)
  );

  always #5 clk = ~clk;

  // One clock: apply inputs, update the model on the edge, settle 1 time unit.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic rs);
    bit push, pop;
    write = w; data_write = d; next_read = r; rst = rs;
    @(posedge clk);
    if (!rs) begin
      mq.delete();
    end else begin
      pop  = r && (mq.size() != 0);
      push = w && (mq.size() != 4);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: got e/f/af=%b%b%b expected 100", empty, full, almost_full);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b1);
      checks++;
      if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
        failures++;
        $display("FAIL reset_pop_empty: got e/f/af=%b%b%b expected 100", empty, full, almost_full);
      end
    end
  endtask

  task automatic test_fill();
    logic [7:0] vals [5];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, vals[i], 1'b0, 1'b1);
      checks++;
      if (empty !== 1'b0 || full !== (i >= 3) || almost_full !== (i == 2)) begin
        failures++;
        $display("FAIL fill_flags_%0d: got e/f/af=%b%b%b expected 0%b%b",
                 i, empty, full, almost_full, (i >= 3), (i == 2));
      end
      checks++;
      if (data_read !== 8'h11) begin
        failures++;
        $display("FAIL fill_head_%0d: got %02h expected 11", i, data_read);
      end
    end
  endtask

  task automatic test_fwft_drain();
    logic [7:0] exp_v [3];
    exp_v = '{8'h22, 8'h33, 8'h44};
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (data_read !== 8'h11 || full !== 1'b1) begin
      failures++;
      $display("FAIL fwft_head: got %02h full=%b expected 11 full=1", data_read, full);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b1);
      checks++;
      if (data_read !== exp_v[i] || empty !== 1'b0) begin
        failures++;
        $display("FAIL drain_%0d: got %02h empty=%b expected %02h empty=0", i, data_read, empty, exp_v[i]);
      end
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty: got e/f/af=%b%b%b expected 100", empty, full, almost_full);
    end
  endtask

  task automatic test_simultaneous();
    cyc(1'b1, 8'hA0, 1'b0, 1'b1);
    cyc(1'b1, 8'hA1, 1'b0, 1'b1);
    checks++;
    if (data_read !== 8'hA0) begin
      failures++;
      $display("FAIL simul_pre: got %02h expected a0", data_read);
    end
    cyc(1'b1, 8'hA2, 1'b1, 1'b1);
    checks++;
    if (data_read !== 8'hA1 || empty !== 1'b0 || full !== 1'b0 || almost_full !== 1'b0) begin
      failures++;
      $display("FAIL simul_rw: got %02h e/f/af=%b%b%b expected a1 000", data_read, empty, full, almost_full);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (data_read !== 8'hA2 || empty !== 1'b0) begin
      failures++;
      $display("FAIL simul_next: got %02h empty=%b expected a2 empty=0", data_read, empty);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL simul_count: got empty=%b expected 1", empty);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] got[$];
    logic [7:0] nxt;
    int occ;
    bit w, r;
    nxt = 8'h00;
    occ = 0;
    for (int c = 0; c < 40 && got.size() < 10; c++) begin
      w = (nxt < 8'd10) && (occ < 3);
      r = (occ > 1) || (nxt >= 8'd10 && occ > 0);
      if (r && !empty) got.push_back(data_read);
      cyc(w, nxt, r, 1'b1);
      if (w) nxt++;
      occ = occ + int'(w) - int'(r);
    end
    checks++;
    if (got.size() != 10) begin
      failures++;
      $display("FAIL wrap_count: got %0d words expected 10", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'(i)) begin
        failures++;
        $display("FAIL wrap_order_%0d: got %02h expected %02h", i, got[i], 8'(i));
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL wrap_empty: got empty=%b expected 1", empty);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 8'h01, 1'b0, 1'b1);
    cyc(1'b1, 8'h02, 1'b0, 1'b1);
    cyc(1'b1, 8'h03, 1'b0, 1'b1);
    checks++;
    if (almost_full !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre: got almost_full=%b expected 1", almost_full);
    end
    cyc(1'b1, 8'h04, 1'b0, 1'b0);
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_flags: got e/f/af=%b%b%b expected 100", empty, full, almost_full);
    end
    cyc(1'b1, 8'h7E, 1'b0, 1'b1);
    checks++;
    if (data_read !== 8'h7E || empty !== 1'b0 || almost_full !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_write: got %02h empty=%b af=%b expected 7e 0 0", data_read, empty, almost_full);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_single: got empty=%b expected 1", empty);
    end
  endtask

  task automatic test_random();
    bit w, r, rs;
    for (int c = 0; c < 400; c++) begin
      w  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 45);
      rs = ($urandom_range(0, 99) >= 2);
      cyc(w, 8'($urandom), r, rs);
      checks++;
      if (empty !== (mq.size() == 0) || full !== (mq.size() == 4) ||
          almost_full !== (mq.size() == 3)) begin
        failures++;
        $display("FAIL rand_flags_%0d: got e/f/af=%b%b%b expected occupancy %0d",
                 c, empty, full, almost_full, mq.size());
      end
      if (mq.size() != 0) begin
        checks++;
        if (data_read !== mq[0]) begin
          failures++;
          $display("FAIL rand_data_%0d: got %02h expected %02h", c, data_read, mq[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_fwft_drain();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4: storage depth in words; must equal 2**LOG_NUM_SLOTS.
REQ-002 SHALL have parameter LOG_NUM_SLOTS, default 2: pointer width in bits.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: word width in bits.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port data_write  input  DATA_WIDTH  word to store.
REQ-007 SHALL have port write  input  1  write request.
REQ-008 SHALL have port full  output  1  no free slot.
REQ-009 SHALL have port almost_full  output  1  exactly one free slot.
REQ-010 SHALL have port data_read  output  DATA_WIDTH  oldest stored word (first-word fall-through).
REQ-011 SHALL have port next_read  input  1  pop request; consumes word currently on data_read.
REQ-012 SHALL have port empty  output  1  no stored word.

Function
REQ-013 SHALL hold write pointer, read pointer (LOG_NUM_SLOTS bits each, wrap modulo NUM_SLOTS) and occupancy count (LOG_NUM_SLOTS+1 bits, range 0..NUM_SLOTS).
REQ-014 SHALL accept a write on a clock edge when write=1 and full=0: store data_write at write pointer, advance write pointer.
REQ-015 SHALL ignore write when full=1, regardless of next_read in the same cycle; no storage change, no pointer change.
REQ-016 SHALL accept a pop on a clock edge when next_read=1 and empty=0: advance read pointer.
REQ-017 SHALL ignore next_read when empty=1; a simultaneous write is still accepted (no bypass to data_read in that cycle).
REQ-018 SHALL, on simultaneous accepted write and pop, advance both pointers and leave count unchanged.
REQ-019 SHALL increment count on accepted write only, decrement on accepted pop only.
REQ-020 SHALL drive data_read combinationally from storage at the read pointer; valid whenever empty=0, zero added latency.
REQ-021 SHALL make a written word visible on data_read, with empty=0, in the cycle after the accepting edge.
REQ-022 SHALL derive flags combinationally from registered count only: empty = (count==0), full = (count==NUM_SLOTS), almost_full = (count==NUM_SLOTS-1).
REQ-023 SHALL never assert full and almost_full together, nor empty and full together.
REQ-024 SHALL preserve write order on data_read across pointer wrap-around.
REQ-025 SHALL leave data_read content undefined while empty=1; consumers must qualify with empty.

Reset
REQ-026 SHALL, on a rising edge with rst=0, clear both pointers and count; outputs become empty=1, full=0, almost_full=0 from the next cycle.
REQ-027 SHALL give reset priority over write and next_read in the same cycle; words stored before reset are discarded.
REQ-028 SHALL not require storage array reset.

Verification (NUM_SLOTS=4, DATA_WIDTH=8)
REQ-029 SHALL verify post-reset: hold rst=0 two cycles, release -> empty=1, full=0, almost_full=0; next_read pulses leave flags unchanged.
REQ-030 SHALL verify fill: write 0x11,0x22,0x33,0x44 on consecutive edges -> after 3rd write almost_full=1; after 4th full=1, almost_full=0; 5th write 0x55 ignored.
REQ-031 SHALL verify FWFT drain: after the fill, data_read=0x11 with no pop; pop each cycle -> 0x22,0x33,0x44, then empty=1.
REQ-032 SHALL verify simultaneous operations at 2 entries (0xA0,0xA1): write 0xA2 plus pop -> count stays 2, data_read=0xA1, flags unchanged.
REQ-033 SHALL verify wrap-around: 10 interleaved write/pop cycles of 0x00..0x09 at occupancy 1-3 -> output sequence 0x00..0x09 exact, no loss or duplication.
REQ-034 SHALL verify reset mid-operation: with 3 entries stored, rst=0 one cycle with write=1 -> empty=1, count 0; next write 0x7E appears on data_read one cycle later.
